gpr_wb_arbiter: RTL and testbench
=================================

Name: gpr_wb_arbiter

Overview:
- Shares the single GPR write port (write enable, 3-bit destination, 16-bit data) among NUM_REQ writeback requesters (ALU, load unit, move/immediate path) using round-robin arbitration with valid/ready handshakes.
- Keeps a per-register pending-write scoreboard (reserve at issue, release at writeback) that decode uses to detect read-after-write hazards.
- Sits between the execute/memory stages and the GPR file; its registered write outputs drive the GPR write port directly.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..4); index 0 has highest priority after reset.
- DATA_W, 16, register data width.
- ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W.
- CNT_W, 2, width of the per-register pending counter; maximum outstanding writes per register = 2**CNT_W-1.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  requester i holds a writeback.
- req_ready  out  NUM_REQ  one-hot grant; transfer when valid&ready.
- req_dest  in  NUM_REQ*ADDR_W  packed destination, slice i for requester i.
- req_data  in  NUM_REQ*DATA_W  packed write data, slice i.
- reg_write_en  out  1  to GPR write enable (registered).
- reg_write_dest  out  ADDR_W  to GPR write destination (registered).
- reg_write_data  out  DATA_W  to GPR write data (registered).
- reserve_en  in  1  decode issues an instruction writing reserve_dest.
- reserve_dest  in  ADDR_W  register being reserved.
- reserve_ready  out  1  0 when the counter for reserve_dest is saturated; a reserve with reserve_ready=0 is ignored.
- rd_addr_1, rd_addr_2  in  ADDR_W each  decode source operands.
- rd_pending_1, rd_pending_2  out  1 each  source has an outstanding write (combinational from scoreboard).
- grant_id  out  2  index of the last granted requester (registered).

Behaviour:
- Reset (async on rst_n low):
  - reg_write_en=0, reg_write_dest=0, reg_write_data=0, grant_id=0.
  - RR pointer = 0; all pending counters = 0.
  - req_ready=0 while rst_n low.
- Arbitration (combinational, each cycle):
  - Search valid requesters starting at the RR pointer, wrapping modulo NUM_REQ; the first valid one gets req_ready=1, all others 0.
  - req_ready never asserts without the matching req_valid.
  - On a grant, the pointer moves to winner+1 (mod NUM_REQ) at the clock edge; with no grant it holds.
- Write port:
  - A grant in cycle N registers reg_write_en=1 with the winner's dest/data, visible in cycle N+1 (latency 1). The GPR file commits at the N+1 edge.
  - With no grant, reg_write_en=0 next cycle; dest/data hold their previous values.
  - Throughput is one writeback per cycle; the port never stalls.
- Requester rule: valid, dest and data stay stable until ready is seen; the arbiter holds no skid buffer.
- Scoreboard (one CNT_W counter per register):
  - Increment on accepted reserve_en; decrement on every cycle with reg_write_en=1, for reg_write_dest.
  - Same-register reserve and release in one cycle: counter unchanged.
  - Release with counter 0 (unreserved write): counter stays 0, no underflow.
  - rd_pending_k = (counter[rd_addr_k] != 0).
  - The register being written this cycle still reads pending, because the GPR write lands at the edge.
- Reset mid-operation: in-flight writes are lost and the scoreboard clears; upstream flushes with the same reset.

Optional Feature:
- Macro GPR_WB_BYPASS_EN.
- Defined: adds outputs rd_fwd_valid_1/2 (1 bit) and rd_fwd_data_1/2 (DATA_W).
  - rd_fwd_valid_k = reg_write_en & (reg_write_dest == rd_addr_k) & (counter[rd_addr_k] == 1); rd_fwd_data_k = reg_write_data.
  - When rd_fwd_valid_k=1, rd_pending_k is forced to 0, so decode may consume the forwarded value in the same cycle.
- Undefined: these ports are absent and rd_pending behaves as above.

Decomposition:
- Package gpr_pkg: constants GPR_DATA_W=16, GPR_ADDR_W=3, GPR_NUM_REGS=8; typedef gpr_addr_t and gpr_data_t.
- Sub-module rr_arbiter (NUM_REQ-wide request vector -> one-hot grant, pointer update); the scoreboard stays inline.

Test Plan:
- Reset release, single requester: req_valid=001, dest=3, data=16'hA5A5 -> req_ready=001 same cycle; next cycle reg_write_en=1, dest=3, data=A5A5; grant_id=0.
- All three valid for 6 cycles -> grants 0,1,2,0,1,2; reg_write_en=1 every cycle with the matching data.
- Reserve r5 twice -> rd_pending(r5)=1; after two writebacks to r5 -> pending=0; a third reserve at counter 3 -> reserve_ready=0 and the counter stays 3.
- Same cycle: reserve r2 and writeback r2 issued with counter=1 -> counter stays 1 and pending stays 1.
- rst_n pulsed low mid-burst (asynchronous, between edges) -> reg_write_en=0 immediately, all pending=0, next grant from index 0.
- GPR_WB_BYPASS_EN: reserve r4, write 16'h1234 -> in the write cycle with rd_addr_1=4: rd_fwd_valid_1=1, rd_fwd_data_1=1234, rd_pending_1=0.

Source files
------------

// File: rtl/gpr_pkg.sv
// ============================================================================
// Module      : gpr_pkg
// Description : Shared GPR widths and types for the writeback path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpr_pkg;
    localparam int GPR_DATA_W   = 16;
    localparam int GPR_ADDR_W   = 3;
    localparam int GPR_NUM_REGS = 8;

    typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;
    typedef logic [GPR_DATA_W-1:0] gpr_data_t;
endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin one-hot arbiter (up to 4 requesters), pointer
//               advances past the winner on every grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               gnt_any_o,
    output logic [1:0]         gnt_idx_o
);
    logic [1:0]         ptr_q;
    logic [1:0]         ptr_d;
    logic [1:0]         cand;
    logic [1:0]         idx_w;
    logic               found;
    logic [NUM_REQ-1:0] gnt_w;

    always_comb begin
        gnt_w = '0;
        found = 1'b0;
        idx_w = 2'd0;
        cand  = 2'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = 2'((int'(ptr_q) + k) % NUM_REQ);
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && (cand == 2'(j)) && req_i[j]) begin
                    found    = 1'b1;
                    gnt_w[j] = 1'b1;
                    idx_w    = 2'(j);
                end
            end
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (idx_w == 2'(NUM_REQ - 1)) ? 2'd0 : idx_w + 2'd1;
        end
    end

    // Grants are suppressed combinationally while reset is held.
    assign gnt_o     = rst_n ? gnt_w : '0;
    assign gnt_any_o = rst_n & found;
    assign gnt_idx_o = idx_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

`default_nettype wire

// File: rtl/gpr_wb_arbiter.sv
// ============================================================================
// Module      : gpr_wb_arbiter
// Description : Round-robin GPR writeback arbiter with pending-write
//               scoreboard. Optional bypass outputs via GPR_WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpr_wb_arbiter
    import gpr_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = GPR_DATA_W,
    parameter int ADDR_W  = GPR_ADDR_W,
    parameter int CNT_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_dest,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      reg_write_en,
    output logic [ADDR_W-1:0]         reg_write_dest,
    output logic [DATA_W-1:0]         reg_write_data,
    input  logic                      reserve_en,
    input  logic [ADDR_W-1:0]         reserve_dest,
    output logic                      reserve_ready,
    input  logic [ADDR_W-1:0]         rd_addr_1,
    input  logic [ADDR_W-1:0]         rd_addr_2,
    output logic                      rd_pending_1,
    output logic                      rd_pending_2,
    output logic [1:0]                grant_id
`ifdef GPR_WB_BYPASS_EN
    ,
    output logic                      rd_fwd_valid_1,
    output logic [DATA_W-1:0]         rd_fwd_data_1,
    output logic                      rd_fwd_valid_2,
    output logic [DATA_W-1:0]         rd_fwd_data_2
`endif
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_REQ-1:0] gnt;
    logic               gnt_any;
    logic [1:0]         gnt_idx;
    logic [ADDR_W-1:0]  sel_dest;
    logic [DATA_W-1:0]  sel_data;

    logic               reg_write_en_q;
    logic [ADDR_W-1:0]  reg_write_dest_q, reg_write_dest_d;
    logic [DATA_W-1:0]  reg_write_data_q, reg_write_data_d;
    logic [1:0]         grant_id_q, grant_id_d;
    logic [CNT_W-1:0]   cnt_q [NUM_REGS];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_valid),
        .gnt_o     (gnt),
        .gnt_any_o (gnt_any),
        .gnt_idx_o (gnt_idx)
    );

    assign req_ready = gnt;

    always_comb begin
        sel_dest = '0;
        sel_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (gnt[j]) begin
                sel_dest = req_dest[j*ADDR_W +: ADDR_W];
                sel_data = req_data[j*DATA_W +: DATA_W];
            end
        end
        reg_write_dest_d = gnt_any ? sel_dest : reg_write_dest_q;
        reg_write_data_d = gnt_any ? sel_data : reg_write_data_q;
        grant_id_d       = gnt_any ? gnt_idx  : grant_id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_en_q   <= 1'b0;
            reg_write_dest_q <= '0;
            reg_write_data_q <= '0;
            grant_id_q       <= 2'd0;
        end else begin
            reg_write_en_q   <= gnt_any;
            reg_write_dest_q <= reg_write_dest_d;
            reg_write_data_q <= reg_write_data_d;
            grant_id_q       <= grant_id_d;
        end
    end

    assign reg_write_en   = reg_write_en_q;
    assign reg_write_dest = reg_write_dest_q;
    assign reg_write_data = reg_write_data_q;
    assign grant_id       = grant_id_q;

    assign reserve_ready = (cnt_q[reserve_dest] != CNT_MAX);

    // Release follows the registered write port, i.e. the cycle the GPR commits.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
        logic             inc;
        logic             dec;
        logic [CNT_W-1:0] cnt_d;

        assign inc = reserve_en && reserve_ready && (reserve_dest == ADDR_W'(r));
        assign dec = reg_write_en_q && (reg_write_dest_q == ADDR_W'(r));

        always_comb begin
            cnt_d = cnt_q[r];
            if (inc && !dec) begin
                cnt_d = cnt_q[r] + CNT_W'(1);
            end else if (dec && !inc && (cnt_q[r] != '0)) begin
                cnt_d = cnt_q[r] - CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[r] <= '0;
            end else begin
                cnt_q[r] <= cnt_d;
            end
        end
    end

`ifdef GPR_WB_BYPASS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    assign rd_fwd_valid_1 = reg_write_en_q && (reg_write_dest_q == rd_addr_1) && (cnt_q[rd_addr_1] == CNT_ONE);
    assign rd_fwd_valid_2 = reg_write_en_q && (reg_write_dest_q == rd_addr_2) && (cnt_q[rd_addr_2] == CNT_ONE);
    assign rd_fwd_data_1  = reg_write_data_q;
    assign rd_fwd_data_2  = reg_write_data_q;
    assign rd_pending_1   = (cnt_q[rd_addr_1] != '0) && !rd_fwd_valid_1;
    assign rd_pending_2   = (cnt_q[rd_addr_2] != '0) && !rd_fwd_valid_2;
`else
    assign rd_pending_1   = (cnt_q[rd_addr_1] != '0);
    assign rd_pending_2   = (cnt_q[rd_addr_2] != '0);
`endif
endmodule

`default_nettype wire

// File: tb/tb_gpr_wb_arbiter.sv
// ============================================================================
// Module      : tb_gpr_wb_arbiter
// Description : Self-checking bench for gpr_wb_arbiter with a queue-free
//               behavioural model (honours GPR_WB_BYPASS_EN when defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpr_wb_arbiter;
    localparam int NR   = 3;
    localparam int DW   = 16;
    localparam int AW   = 3;
    localparam int NRG  = 8;
    localparam int CMAX = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NR-1:0]  req_valid;
    logic [NR-1:0]  req_ready;
    logic [AW-1:0]  td   [NR];
    logic [DW-1:0]  tdat [NR];
    logic [NR*AW-1:0] req_dest;
    logic [NR*DW-1:0] req_data;
    logic           reg_write_en;
    logic [AW-1:0]  reg_write_dest;
    logic [DW-1:0]  reg_write_data;
    logic           reserve_en;
    logic [AW-1:0]  reserve_dest;
    logic           reserve_ready;
    logic [AW-1:0]  rd_addr_1, rd_addr_2;
    logic           rd_pending_1, rd_pending_2;
    logic [1:0]     grant_id;
`ifdef GPR_WB_BYPASS_EN
    logic           rd_fwd_valid_1, rd_fwd_valid_2;
    logic [DW-1:0]  rd_fwd_data_1, rd_fwd_data_2;
`endif

    assign req_dest = {td[2], td[1], td[0]};
    assign req_data = {tdat[2], tdat[1], tdat[0]};

    always #5 clk = ~clk;

    gpr_wb_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dest       (req_dest),
        .req_data       (req_data),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .reserve_en     (reserve_en),
        .reserve_dest   (reserve_dest),
        .reserve_ready  (reserve_ready),
        .rd_addr_1      (rd_addr_1),
        .rd_addr_2      (rd_addr_2),
        .rd_pending_1   (rd_pending_1),
        .rd_pending_2   (rd_pending_2),
        .grant_id       (grant_id)
`ifdef GPR_WB_BYPASS_EN
        ,
        .rd_fwd_valid_1 (rd_fwd_valid_1),
        .rd_fwd_data_1  (rd_fwd_data_1),
        .rd_fwd_valid_2 (rd_fwd_valid_2),
        .rd_fwd_data_2  (rd_fwd_data_2)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state only.
    int            m_ptr;
    int            m_cnt [NRG];
    int            m_gid;
    int            m_last;
    logic          m_we;
    logic [AW-1:0] m_dest;
    logic [DW-1:0] m_data;

    task automatic model_reset();
        m_ptr = 0; m_gid = 0; m_last = -1;
        m_we = 1'b0; m_dest = '0; m_data = '0;
        for (int r = 0; r < NRG; r++) m_cnt[r] = 0;
    endtask

    function automatic int rr_pick(int p, logic [NR-1:0] v);
        logic [NR-1:0] s;
        for (int k = 0; k < NR; k++) begin
            s = v >> ((p + k) % NR);
            if (s[0]) return (p + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] exp_ready(logic [NR-1:0] v);
        int w;
        logic [NR-1:0] one;
        w = rr_pick(m_ptr, v);
        one = 1;
        return (w < 0) ? '0 : (one << w);
    endfunction

    function automatic logic exp_fwd(logic [AW-1:0] a);
`ifdef GPR_WB_BYPASS_EN
        return m_we && (m_dest == a) && (m_cnt[a] == 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_pending(logic [AW-1:0] a);
        return (m_cnt[a] != 0) && !exp_fwd(a);
    endfunction

    // Apply the spec rules for the coming edge, then step past it.
    task automatic advance();
        int w;
        int nc [NRG];
        logic inc, dec;
        w = rr_pick(m_ptr, req_valid);
        for (int r = 0; r < NRG; r++) begin
            inc = reserve_en && (m_cnt[reserve_dest] != CMAX) && (int'(reserve_dest) == r);
            dec = m_we && (int'(m_dest) == r);
            nc[r] = m_cnt[r];
            if (inc && !dec) nc[r] = m_cnt[r] + 1;
            else if (dec && !inc && m_cnt[r] > 0) nc[r] = m_cnt[r] - 1;
        end
        for (int r = 0; r < NRG; r++) m_cnt[r] = nc[r];
        if (w >= 0) begin
            m_we = 1'b1; m_dest = td[w]; m_data = tdat[w]; m_gid = w;
            m_ptr = (w + 1) % NR;
        end else begin
            m_we = 1'b0;
        end
        m_last = w;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; reserve_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '1; reserve_en = 1'b0; reserve_dest = 3'd0;
        rd_addr_1 = 3'd0; rd_addr_2 = 3'd7;
        for (int i = 0; i < NR; i++) begin td[i] = 3'(i); tdat[i] = 16'(i); end
        repeat (2) @(posedge clk);
        #2;
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b exp 000", req_ready); end
        checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", reg_write_en); end
        checks++; if (reg_write_dest !== 3'd0 || reg_write_data !== 16'h0) begin errors++; $display("FAIL reset_wport got %h/%h exp 0/0", reg_write_dest, reg_write_data); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid got %0d exp 0", grant_id); end
        checks++; if (rd_pending_1 !== 1'b0 || rd_pending_2 !== 1'b0 || reserve_ready !== 1'b1) begin errors++; $display("FAIL reset_sb got %b%b%b exp 001", rd_pending_1, rd_pending_2, reserve_ready); end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        req_valid = 3'b001; td[0] = 3'd3; tdat[0] = 16'hA5A5;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ready got %b exp 001", req_ready); end
        advance();
        req_valid = '0;
        #1;
        checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd3 || reg_write_data !== 16'hA5A5) begin errors++; $display("FAIL single_write got %b/%0d/%h exp 1/3/a5a5", reg_write_en, reg_write_dest, reg_write_data); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_gid got %0d exp 0", grant_id); end
        advance();
        checks++; if (reg_write_en !== 1'b0 || reg_write_dest !== 3'd3 || reg_write_data !== 16'hA5A5) begin errors++; $display("FAIL idle_hold got %b/%0d/%h exp 0/3/a5a5", reg_write_en, reg_write_dest, reg_write_data); end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] prev;
        do_reset();
        for (int i = 0; i < NR; i++) begin td[i] = 3'(i + 1); tdat[i] = 16'(16'h1000 * (i + 1)); end
        req_valid = 3'b111;
        prev = '0;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (req_ready !== (3'b001 << (k % 3))) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, 3'b001 << (k % 3)); end
            if (k > 0) begin
                checks++; if (reg_write_en !== 1'b1 || reg_write_data !== prev || grant_id !== 2'((k - 1) % 3)) begin errors++; $display("FAIL rr_write[%0d] got %b/%h/%0d exp 1/%h/%0d", k, reg_write_en, reg_write_data, grant_id, prev, (k - 1) % 3); end
            end
            prev = tdat[k % 3];
            advance();
            tdat[k % 3] = tdat[k % 3] + 16'h0001;
        end
        req_valid = '0;
        #1;
        checks++; if (reg_write_en !== 1'b1 || reg_write_data !== prev || grant_id !== 2'd2) begin errors++; $display("FAIL rr_last got %b/%h/%0d exp 1/%h/2", reg_write_en, reg_write_data, grant_id, prev); end
        advance();
    endtask

    task automatic test_scoreboard();
        do_reset();
        rd_addr_1 = 3'd5; reserve_dest = 3'd5; reserve_en = 1'b1;
        advance(); advance();
        reserve_en = 1'b0;
        #1;
        checks++; if (rd_pending_1 !== 1'b1 || reserve_ready !== 1'b1) begin errors++; $display("FAIL sb_two_res got %b/%b exp 1/1", rd_pending_1, reserve_ready); end
        req_valid = 3'b001; td[0] = 3'd5; tdat[0] = 16'h0505;
        advance();
        tdat[0] = 16'h0506;
        advance();
        req_valid = '0;
        #1;
        checks++; if (rd_pending_1 !== exp_pending(3'd5)) begin errors++; $display("FAIL sb_mid got %b exp %b", rd_pending_1, exp_pending(3'd5)); end
        advance();
        checks++; if (rd_pending_1 !== 1'b0) begin errors++; $display("FAIL sb_released got %b exp 0", rd_pending_1); end
        reserve_en = 1'b1;
        advance(); advance(); advance();
        reserve_en = 1'b0;
        #1;
        checks++; if (reserve_ready !== 1'b0) begin errors++; $display("FAIL sb_sat got %b exp 0", reserve_ready); end
        reserve_en = 1'b1;
        advance();
        reserve_en = 1'b0;
        #1;
        checks++; if (reserve_ready !== 1'b0 || rd_pending_1 !== 1'b1) begin errors++; $display("FAIL sb_sat_hold got %b/%b exp 0/1", reserve_ready, rd_pending_1); end
        req_valid = 3'b001;
        advance(); advance(); advance();
        req_valid = '0;
        #1;
        checks++; if (rd_pending_1 !== exp_pending(3'd5)) begin errors++; $display("FAIL sb_drain_mid got %b exp %b", rd_pending_1, exp_pending(3'd5)); end
        advance();
        checks++; if (rd_pending_1 !== 1'b0 || reserve_ready !== 1'b1) begin errors++; $display("FAIL sb_drained got %b/%b exp 0/1", rd_pending_1, reserve_ready); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        rd_addr_2 = 3'd2; reserve_dest = 3'd2; reserve_en = 1'b1;
        advance();
        reserve_en = 1'b0;
        req_valid = 3'b010; td[1] = 3'd2; tdat[1] = 16'h0202;
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL same_ready got %b exp 010", req_ready); end
        advance();
        req_valid = '0; reserve_en = 1'b1;
        #1;
        checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd2 || reserve_ready !== 1'b1) begin errors++; $display("FAIL same_setup got %b/%0d/%b exp 1/2/1", reg_write_en, reg_write_dest, reserve_ready); end
        advance();
        reserve_en = 1'b0;
        #1;
        checks++; if (rd_pending_2 !== 1'b1 || reg_write_en !== 1'b0) begin errors++; $display("FAIL same_cycle got %b/%b exp 1/0", rd_pending_2, reg_write_en); end
        req_valid = 3'b010;
        advance();
        req_valid = '0;
        advance(); advance();
        checks++; if (rd_pending_2 !== 1'b0) begin errors++; $display("FAIL same_cleanup got %b exp 0", rd_pending_2); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < NR; i++) begin td[i] = 3'(i); tdat[i] = 16'($urandom); end
        req_valid = 3'b111; reserve_en = 1'b1; reserve_dest = 3'd6; rd_addr_1 = 3'd6;
        advance();
        reserve_en = 1'b0;
        advance();
        #1;
        checks++; if (reg_write_en !== 1'b1 || rd_pending_1 !== 1'b1) begin errors++; $display("FAIL arst_pre got %b/%b exp 1/1", reg_write_en, rd_pending_1); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (reg_write_en !== 1'b0 || req_ready !== 3'b000 || rd_pending_1 !== 1'b0 || grant_id !== 2'd0 || reg_write_data !== 16'h0) begin errors++; $display("FAIL arst_now got %b/%b/%b/%0d/%h exp 0/000/0/0/0", reg_write_en, req_ready, rd_pending_1, grant_id, reg_write_data); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL arst_first got %b exp 001", req_ready); end
        advance();
        req_valid = '0;
        checks++; if (reg_write_en !== 1'b1 || grant_id !== 2'd0 || reg_write_data !== tdat[0]) begin errors++; $display("FAIL arst_grant got %b/%0d/%h exp 1/0/%h", reg_write_en, grant_id, reg_write_data, tdat[0]); end
        advance();
    endtask

`ifdef GPR_WB_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        reserve_en = 1'b1; reserve_dest = 3'd4;
        advance();
        reserve_en = 1'b0;
        req_valid = 3'b001; td[0] = 3'd4; tdat[0] = 16'h1234; rd_addr_1 = 3'd4; rd_addr_2 = 3'd4;
        advance();
        req_valid = '0;
        #1;
        checks++; if (rd_fwd_valid_1 !== 1'b1 || rd_fwd_data_1 !== 16'h1234 || rd_pending_1 !== 1'b0) begin errors++; $display("FAIL byp_1 got %b/%h/%b exp 1/1234/0", rd_fwd_valid_1, rd_fwd_data_1, rd_pending_1); end
        checks++; if (rd_fwd_valid_2 !== 1'b1 || rd_fwd_data_2 !== 16'h1234 || rd_pending_2 !== 1'b0) begin errors++; $display("FAIL byp_2 got %b/%h/%b exp 1/1234/0", rd_fwd_valid_2, rd_fwd_data_2, rd_pending_2); end
        advance();
        checks++; if (rd_fwd_valid_1 !== 1'b0 || rd_pending_1 !== 1'b0) begin errors++; $display("FAIL byp_after got %b/%b exp 0/0", rd_fwd_valid_1, rd_pending_1); end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    req_valid[i] = 1'b1;
                    td[i]   = 3'($urandom_range(0, 7));
                    tdat[i] = 16'($urandom);
                end
            end
            reserve_en   = ($urandom_range(0, 9) < 4);
            reserve_dest = 3'($urandom_range(0, 7));
            rd_addr_1    = 3'($urandom_range(0, 7));
            rd_addr_2    = 3'($urandom_range(0, 7));
            #1;
            checks++; if (req_ready !== exp_ready(req_valid)) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", n, req_ready, exp_ready(req_valid)); end
            checks++; if (reg_write_en !== m_we || reg_write_dest !== m_dest || reg_write_data !== m_data || grant_id !== 2'(m_gid)) begin errors++; $display("FAIL rnd_wport[%0d] got %b/%0d/%h/%0d exp %b/%0d/%h/%0d", n, reg_write_en, reg_write_dest, reg_write_data, grant_id, m_we, m_dest, m_data, m_gid); end
            checks++; if (reserve_ready !== (m_cnt[reserve_dest] != CMAX)) begin errors++; $display("FAIL rnd_resrdy[%0d] got %b exp %b", n, reserve_ready, m_cnt[reserve_dest] != CMAX); end
            checks++; if (rd_pending_1 !== exp_pending(rd_addr_1) || rd_pending_2 !== exp_pending(rd_addr_2)) begin errors++; $display("FAIL rnd_pending[%0d] got %b%b exp %b%b", n, rd_pending_1, rd_pending_2, exp_pending(rd_addr_1), exp_pending(rd_addr_2)); end
`ifdef GPR_WB_BYPASS_EN
            checks++; if (rd_fwd_valid_1 !== exp_fwd(rd_addr_1) || rd_fwd_valid_2 !== exp_fwd(rd_addr_2) || rd_fwd_data_1 !== m_data) begin errors++; $display("FAIL rnd_fwd[%0d] got %b%b/%h exp %b%b/%h", n, rd_fwd_valid_1, rd_fwd_valid_2, rd_fwd_data_1, exp_fwd(rd_addr_1), exp_fwd(rd_addr_2), m_data); end
`endif
            advance();
            if (m_last >= 0) req_valid[m_last] = 1'b0;
        end
        req_valid = '0; reserve_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_scoreboard();
        test_same_cycle();
        test_async_reset();
`ifdef GPR_WB_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
